// File: rtl/mem_arbiter_if.sv
// Bundles the two requester handshakes and the memory macro pins of mem_arbiter.
// The arbiter takes the slave side; the surrounding logic takes the master side.
interface mem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              req_a;
    logic              req_b;
    logic              we_a;
    logic              we_b;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_a;
    logic [DATA_W-1:0] wdata_b;
    logic              ack_a;
    logic              ack_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              busy;
    logic              m_cs;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_din;
    logic [DATA_W-1:0] m_dout;

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, m_dout,
        output ack_a, ack_b, rdata_a, rdata_b, busy, m_cs, m_we, m_addr, m_din
    );

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, m_dout,
        input  ack_a, ack_b, rdata_a, rdata_b, busy, m_cs, m_we, m_addr, m_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter for a single-port memory macro; zero-fills the
// memory after every reset, then serves one request at a time via req/ack.
module mem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_ACCESS,
        S_CAPT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              prio_q, prio_d;
    logic              ack_a_q, ack_a_d;
    logic              ack_b_q, ack_b_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

    // Latched winner (0 = A, 1 = B) and its command
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              win;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_CLEAR;
            cnt_q     <= '0;
            prio_q    <= 1'b0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prio_q    <= prio_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    always_ff @(posedge clk) begin
        gnt_q   <= gnt_d;
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prio_d    = prio_q;
        gnt_d     = gnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        win       = prio_q;

        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    // A lone requester wins outright; a tie goes to prio
                    win     = (bus.req_a && bus.req_b) ? prio_q : bus.req_b;
                    gnt_d   = win;
                    prio_d  = ~win;
                    we_d    = win ? bus.we_b    : bus.we_a;
                    addr_d  = win ? bus.addr_b  : bus.addr_a;
                    wdata_d = win ? bus.wdata_b : bus.wdata_a;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    state_d = S_DONE;
                    ack_a_d = ~gnt_q;
                    ack_b_d = gnt_q;
                end else begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                if (gnt_q) begin
                    rdata_b_d = bus.m_dout;
                end else begin
                    rdata_a_d = bus.m_dout;
                end
                ack_a_d = ~gnt_q;
                ack_b_d = gnt_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // Memory pins depend only on registered state, never on requester inputs
    always_comb begin
        bus.busy   = 1'b0;
        bus.m_cs   = 1'b0;
        bus.m_we   = 1'b0;
        bus.m_addr = addr_q;
        bus.m_din  = wdata_q;

        case (state_q)
            S_CLEAR: begin
                bus.busy   = 1'b1;
                bus.m_cs   = 1'b1;
                bus.m_we   = 1'b1;
                bus.m_addr = cnt_q;
                bus.m_din  = '0;
            end
            S_ACCESS: begin
                bus.m_cs = 1'b1;
                bus.m_we = we_q;
            end
            default: begin
                bus.m_cs = 1'b0;
            end
        endcase
    end

    assign bus.ack_a   = ack_a_q;
    assign bus.ack_b   = ack_b_q;
    assign bus.rdata_a = rdata_a_q;
    assign bus.rdata_b = rdata_b_q;
endmodule
